// File: rtl/mips32_pkg.sv
// Shared MIPS-style decode constants and hazard FSM encoding.
// The datapath decoder uses the same field positions and opcodes.
package mips32_pkg;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [5:0] OP_R_LAST     = 6'b000101;
  localparam logic [5:0] OP_LW         = 6'b001000;
  localparam logic [5:0] OP_SW         = 6'b001001;
  localparam logic [5:0] OP_ADDI_FIRST = 6'b001010;
  localparam logic [5:0] OP_ADDI_LAST  = 6'b001100;
  localparam logic [5:0] OP_BNEZ       = 6'b001101;
  localparam logic [5:0] OP_BEQZ       = 6'b001110;
  localparam logic [5:0] OP_HLT        = 6'b111111;
  localparam logic [31:0] NOP          = 32'h0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[RT_HI:RT_LO];
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: IR snapshots and branch/stall in,
// register hold/flush controls and perf counters out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0]      ir_id;
  logic [31:0]      ir_ex;
  logic             br_taken_ex;
  logic             ext_stall;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ir_id, ir_ex, br_taken_ex, ext_stall,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ir_id, ir_ex, br_taken_ex, ext_stall,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_decode.sv
// Load-use detection between the LW in EX and the instruction in ID.
module hazard_decode
  import mips32_pkg::*;
(
  input  logic [5:0] op_id,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [5:0] op_ex,
  input  logic [4:0] rt_ex,
  output logic       load_use
);
  logic is_r, reads_rs, uses_rt;

  assign is_r     = (op_id <= OP_R_LAST);
  // Every defined class except HLT sources rs; only R-type and SW also source rt.
  assign reads_rs = is_r || op_id == OP_LW || op_id == OP_SW ||
                    (op_id >= OP_ADDI_FIRST && op_id <= OP_ADDI_LAST) ||
                    op_id == OP_BNEZ || op_id == OP_BEQZ;
  assign uses_rt  = is_r || op_id == OP_SW;

  assign load_use = (op_ex == OP_LW) && (rt_ex != 5'd0) &&
                    ((reads_rs && rs_id == rt_ex) || (uses_rt && rt_id == rt_ex));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freeze, branch flush, load-use stall and
// HLT drain/halt sequencing, with saturating stall/flush counters.
module pipe_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_e        state_q, state_n;
  logic [DW-1:0]    drain_q, drain_n;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc, load_use, hlt_id;
  logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;

  hazard_decode u_dec (
    .op_id    (f_op(hz.ir_id)),
    .rs_id    (f_rs(hz.ir_id)),
    .rt_id    (f_rt(hz.ir_id)),
    .op_ex    (f_op(hz.ir_ex)),
    .rt_ex    (f_rt(hz.ir_ex)),
    .load_use (load_use)
  );

  assign hlt_id = (f_op(hz.ir_id) == OP_HLT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_n;
      drain_q <= drain_n;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_n     = state_q;
    drain_n     = drain_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    // Inputs are ignored under reset so every control reads as idle.
    if (!rst) begin
      if (hz.ext_stall) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (hz.br_taken_ex) begin
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
              flush_inc   = 1'b1;
            end else if (load_use) begin
              pc_hold     = 1'b1;
              ifid_hold   = 1'b1;
              idex_bubble = 1'b1;
              stall_inc   = 1'b1;
            end else if (hlt_id) begin
              pc_hold     = 1'b1;
              ifid_hold   = 1'b1;
              idex_bubble = 1'b1;
              state_n     = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_HALTED;
              drain_n     = DW'(DRAIN_CYCLES - 1);
            end
          end
          ST_DRAIN: begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            drain_n     = drain_q - DW'(1);
            if (drain_q <= DW'(1)) state_n = ST_HALTED;
          end
          default: begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        endcase
      end
    end
  end

  assign hz.pc_hold     = pc_hold;
  assign hz.ifid_hold   = ifid_hold;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_hold   = idex_hold;
  assign hz.idex_bubble = idex_bubble;
  assign hz.halted      = (state_q == ST_HALTED);
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: constant vector table, directed corner
// sequences and random traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  hz3 ();

  assign hz3.ir_id       = hz.ir_id;
  assign hz3.ir_ex       = hz.ir_ex;
  assign hz3.br_taken_ex = hz.br_taken_ex;
  assign hz3.ext_stall   = hz.ext_stall;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .hz(hz));
  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(3))  dut3 (.clk(clk), .rst(rst), .hz(hz3));

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_hlt;
  int m_left, m_sc, m_fc, m_sc3, m_fc3;

  typedef struct {
    string       name;
    logic [31:0] id;
    logic [31:0] ex;
    logic        br;
    logic        ext;
    logic [4:0]  exp;  // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble}
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] rt_ins(int op, int rs, int rt, int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] it_ins(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic bit ref_load_use(logic [31:0] id, logic [31:0] ex);
    int op_i = int'(id[31:26]);
    bit reads_rs = op_i inside {[0:5], [8:14]};
    bit uses_rt  = op_i inside {[0:5], 9};
    if (ex[31:26] != 6'd8 || ex[20:16] == 5'd0) return 1'b0;
    return (reads_rs && id[25:21] == ex[20:16]) || (uses_rt && id[20:16] == ex[20:16]);
  endfunction

  function automatic int sat(int v, int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, check on the falling edge, advance the model.
  task automatic step(input logic [31:0] id, input logic [31:0] ex,
                      input logic br, input logic ext, input logic r, input int tidx);
    logic [4:0] eo, ao, ao3;
    logic eh;
    bit n_hlt;
    int n_left, n_sc, n_fc, n_sc3, n_fc3;
    hz.ir_id = id; hz.ir_ex = ex; hz.br_taken_ex = br; hz.ext_stall = ext; rst = r;
    @(negedge clk);
    if (r) begin
      m_hlt = 0; m_left = 0; m_sc = 0; m_fc = 0; m_sc3 = 0; m_fc3 = 0;
    end
    n_hlt = m_hlt; n_left = m_left;
    n_sc = m_sc; n_fc = m_fc; n_sc3 = m_sc3; n_fc3 = m_fc3;
    eo = 5'b0;
    eh = m_hlt && m_left == 0;
    if (!r) begin
      if (ext) eo = 5'b11010;
      else if (m_hlt) begin
        eo = 5'b11001;
        if (m_left > 0) n_left = m_left - 1;
      end else if (br) begin
        eo = 5'b00101; n_fc = sat(m_fc, 16); n_fc3 = sat(m_fc3, 3);
      end else if (ref_load_use(id, ex)) begin
        eo = 5'b11001; n_sc = sat(m_sc, 16); n_sc3 = sat(m_sc3, 3);
      end else if (id[31:26] == 6'h3f) begin
        eo = 5'b11001; n_hlt = 1; n_left = DRAIN - 1;
      end
    end
    ao  = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_hold, hz.idex_bubble};
    ao3 = {hz3.pc_hold, hz3.ifid_hold, hz3.ifid_flush, hz3.idex_hold, hz3.idex_bubble};
    chk("outs", 32'(ao), 32'(eo));
    chk("halted", 32'(hz.halted), 32'(eh));
    chk("stall_cnt", 32'(hz.stall_cnt), m_sc);
    chk("flush_cnt", 32'(hz.flush_cnt), m_fc);
    chk("outs_w3", 32'(ao3), 32'(eo));
    chk("halted_w3", 32'(hz3.halted), 32'(eh));
    chk("stall_cnt_w3", 32'(hz3.stall_cnt), m_sc3);
    chk("flush_cnt_w3", 32'(hz3.flush_cnt), m_fc3);
    if (tidx >= 0) chk(tbl[tidx].name, 32'(ao), 32'(tbl[tidx].exp));
    m_hlt = n_hlt; m_left = n_left;
    m_sc = n_sc; m_fc = n_fc; m_sc3 = n_sc3; m_fc3 = n_fc3;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_ir();
    int k = int'($urandom_range(0, 12));
    int op = (k < 6) ? k : k + 2;
    if ($urandom_range(0, 39) == 0) op = 63;
    return {op[5:0], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  initial begin
    logic [31:0] lw3, add, hlt;
    lw3 = it_ins(8, 1, 3, 0);
    add = rt_ins(0, 3, 4, 5);
    hlt = it_ins(63, 0, 0, 0);
    tbl[0]  = '{"lu_add_rs",     add,               lw3,               0, 0, 5'b11001};
    tbl[1]  = '{"lu_r0_none",    rt_ins(0, 0, 4, 5), it_ins(8, 1, 0, 0), 0, 0, 5'b00000};
    tbl[2]  = '{"lu_addi_rt",    it_ins(10, 2, 7, 7), it_ins(8, 1, 7, 0), 0, 0, 5'b00000};
    tbl[3]  = '{"lu_r_rt",       rt_ins(0, 4, 3, 5), lw3,               0, 0, 5'b11001};
    tbl[4]  = '{"lu_sw_rt",      it_ins(9, 1, 3, 0), lw3,               0, 0, 5'b11001};
    tbl[5]  = '{"lu_beqz_rs",    it_ins(14, 3, 0, 0), lw3,              0, 0, 5'b11001};
    tbl[6]  = '{"lu_lw_rt_none", it_ins(8, 2, 3, 0), lw3,               0, 0, 5'b00000};
    tbl[7]  = '{"sw_in_ex_none", add,               it_ins(9, 1, 3, 0), 0, 0, 5'b00000};
    tbl[8]  = '{"br_over_lu",    add,               lw3,               1, 0, 5'b00101};
    tbl[9]  = '{"ext_over_br",   add,               lw3,               1, 1, 5'b11010};
    tbl[10] = '{"ext_alone",     32'h0,             32'h0,             0, 1, 5'b11010};
    tbl[11] = '{"idle",          32'h0,             32'h0,             0, 0, 5'b00000};
    tbl[12] = '{"br_alone",      32'h0,             32'h0,             1, 0, 5'b00101};
    tbl[13] = '{"lu_bnez_rs",    it_ins(13, 3, 0, 0), lw3,              0, 0, 5'b11001};

    rst = 1'b1;
    hz.ir_id = '0; hz.ir_ex = '0; hz.br_taken_ex = 0; hz.ext_stall = 0;
    #1;
    step(add, lw3, 1, 1, 1, -1);  // reset state, inputs gated
    for (int i = 0; i < 14; i++) step(tbl[i].id, tbl[i].ex, tbl[i].br, tbl[i].ext, 0, i);

    // load-use stall lasts one cycle once EX holds a bubble
    step(0, 0, 0, 0, 1, -1);
    step(add, lw3, 0, 0, 0, -1);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
    step(add, 32'h0, 0, 0, 0, -1);
    chk("lu_after_bubble", 32'({hz.pc_hold, hz.ifid_hold, hz.idex_bubble}), 0);

    // branch beats load-use
    step(0, 0, 0, 0, 1, -1);
    step(add, lw3, 1, 0, 0, -1);
    chk("br_lu_flush", 32'(hz.flush_cnt), 1);
    chk("br_lu_stall", 32'(hz.stall_cnt), 0);

    // freeze defers the flush to the first free cycle
    step(0, 0, 0, 0, 1, -1);
    step(0, 0, 1, 1, 0, -1);
    chk("frz_br_flush", 32'(hz.flush_cnt), 0);
    step(0, 0, 1, 0, 0, -1);
    chk("rel_br_flush", 32'(hz.flush_cnt), 1);

    // HLT at N -> halted from N+3
    step(0, 0, 0, 0, 1, -1);
    step(hlt, 0, 0, 0, 0, -1);
    chk("hlt_n1", 32'(hz.halted), 0);
    step(0, 0, 1, 0, 0, -1);
    chk("hlt_n2", 32'(hz.halted), 0);
    step(0, 0, 0, 0, 0, -1);
    chk("hlt_n3", 32'(hz.halted), 1);
    step(0, 0, 1, 0, 0, -1);

    // HLT at N, freeze at N+1..N+2 -> halted from N+5
    step(0, 0, 0, 0, 1, -1);
    step(hlt, 0, 0, 0, 0, -1);
    step(0, 0, 0, 1, 0, -1);
    step(0, 0, 0, 1, 0, -1);
    step(0, 0, 0, 0, 0, -1);
    chk("hlt_frz_n4", 32'(hz.halted), 0);
    step(0, 0, 0, 0, 0, -1);
    chk("hlt_frz_n5", 32'(hz.halted), 1);

    // saturation on the narrow instance
    step(0, 0, 0, 0, 1, -1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, -1);
    chk("flush_sat_w3", 32'(hz3.flush_cnt), 7);
    chk("flush_w16", 32'(hz.flush_cnt), 10);

    // asynchronous reset mid-DRAIN with non-zero counters
    step(add, lw3, 0, 0, 0, -1);
    step(hlt, 0, 0, 0, 0, -1);
    step(0, 0, 0, 0, 0, -1);
    rst = 1'b1;
    #1;
    chk("arst_halted", 32'(hz.halted), 0);
    chk("arst_stall", 32'(hz.stall_cnt), 0);
    chk("arst_flush", 32'(hz.flush_cnt), 0);
    chk("arst_outs", 32'({hz.pc_hold, hz.ifid_hold, hz.idex_bubble}), 0);
    step(0, 0, 0, 0, 1, -1);
    step(0, 0, 0, 0, 0, -1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ex;
      ex = ($urandom_range(0, 1) == 0) ? {6'd8, 5'($urandom_range(0, 3)),
                                         5'($urandom_range(0, 3)), 16'($urandom)} : rnd_ir();
      step(rnd_ir(), ex, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 59) == 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3; number of cycles after HLT in ID before the pipeline reports halted.
REQ-002 Parameter CNT_W, default 16; width of the performance counters.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ir_id  input  32  instruction currently held in the IF/ID register.
REQ-006 ir_ex  input  32  instruction currently held in the ID/EX register.
REQ-007 br_taken_ex  input  1  the branch in EX resolves taken this cycle.
REQ-008 ext_stall  input  1  memory busy; freeze the whole pipeline.
REQ-009 pc_hold  output  1  PC does not update.
REQ-010 ifid_hold  output  1  IF/ID register keeps its value.
REQ-011 ifid_flush  output  1  IF/ID loads NOP (32'h0) instead of fetched word.
REQ-012 idex_hold  output  1  ID/EX register keeps its value.
REQ-013 idex_bubble  output  1  ID/EX loads NOP instead of the decoded instruction.
REQ-014 halted  output  1  pipeline halted; sticky until reset.
REQ-015 stall_cnt  output  CNT_W  count of load-use stall cycles, saturating.
REQ-016 flush_cnt  output  CNT_W  count of taken-branch flushes, saturating.

Function
REQ-017 Opcode is IR[31:26], rs is IR[25:21], rt is IR[20:16]; the encodings are fixed as R-type ALU 6'b000000–000101, LW 6'b001000, SW 6'b001001, ADDI-class 6'b001010–001100, BNEZ 6'b001101, BEQZ 6'b001110, HLT 6'b111111.
REQ-018 load_use SHALL be true when ir_ex is LW, ir_ex.rt != 0, and either ir_id reads rs == ir_ex.rt (all classes except HLT), or ir_id is R-type or SW and ir_id.rt == ir_ex.rt.
REQ-019 The FSM SHALL have the states RUN, DRAIN and HALTED; the outputs are combinational from the state and the inputs.
REQ-020 In RUN, the checks SHALL be made in this priority order: ext_stall, then br_taken_ex, then load_use, then HLT in ID.
REQ-021 ext_stall=1 (any state) -> pc_hold=ifid_hold=idex_hold=1, flush/bubble=0, FSM, drain counter and perf counters unchanged.
REQ-022 RUN with br_taken_ex -> ifid_flush=1, idex_bubble=1, pc_hold=0, and flush_cnt increments; load_use and HLT are ignored that cycle.
REQ-023 RUN with load_use -> pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle, and stall_cnt increments; the next cycle load_use is false because EX holds a bubble.
REQ-024 RUN with HLT in ir_id -> pc_hold=1, ifid_hold=1, idex_bubble=1; go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-025 DRAIN -> same outputs as REQ-024; decrement each non-frozen cycle; at 0 go to HALTED.
REQ-026 HALTED -> pc_hold=ifid_hold=idex_bubble=1 and halted=1; only reset exits.
REQ-027 br_taken_ex is ignored in DRAIN and HALTED, because EX holds only bubbles there.
REQ-028 The counters SHALL saturate at all-ones and never wrap.
REQ-029 When no condition applies, all outputs SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately force state RUN, drain counter 0, stall_cnt=0, flush_cnt=0 and halted=0; this holds mid-DRAIN or mid-freeze too.
REQ-031 While rst=1, the combinational outputs SHALL evaluate as RUN with inputs gated, so that all hold/flush/bubble outputs are 0.
REQ-032 The first rising edge after rst deasserts SHALL be a normal RUN cycle.

Structure
REQ-033 Opcode localparams, the field bit positions and the FSM state encoding SHALL live in shared package mips32_pkg, which is reused by the datapath decode.
REQ-034 The load_use and uses_rt decode SHALL be one combinational sub-module, hazard_decode, instantiated once.
REQ-035 There SHALL be no other sub-modules, and no latches.

Verification
REQ-036 ir_ex=LW r3,0(r1), ir_id=ADD r5,r3,r4 -> one cycle with pc_hold=ifid_hold=idex_bubble=1; stall_cnt 0→1; the next cycle, with a bubble in EX, all outputs are 0.
REQ-037 ir_ex=LW r0,.., ir_id=ADD r5,r0,r4 -> no stall; ir_id=ADDI r5,r2,#7 with LW writing r7 in rt position only -> no stall.
REQ-038 br_taken_ex=1 together with load_use=1 -> ifid_flush=idex_bubble=1, pc_hold=0; flush_cnt +1, stall_cnt unchanged.
REQ-039 HLT in ID at cycle N -> DRAIN for cycles N..N+2 and halted=1 from N+3 onward; ext_stall=1 at N+1 for 2 cycles -> halted at N+5.
REQ-040 ext_stall=1 with br_taken_ex=1 -> only the hold outputs are 1 and flush_cnt is unchanged; after release, the flush is applied in the first free cycle.
REQ-041 Force flush_cnt to 16'hFFFE, then apply 3 taken branches -> the counter stops at 16'hFFFF; assert rst mid-DRAIN -> halted=0 and all counters 0 asynchronously.
